// File: rtl/button_press_ctrl_if.sv
// Button event bundle: debounced level in, event pulses out.
// master drives button_in and observes events; slave is the controller.
interface button_press_ctrl_if;
  logic button_in;
  logic press_pulse;
  logic release_pulse;
  logic click_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  modport master (
    output button_in,
    input  press_pulse,
    input  release_pulse,
    input  click_pulse,
    input  long_pulse,
    input  repeat_pulse,
    input  held
  );

  modport slave (
    input  button_in,
    output press_pulse,
    output release_pulse,
    output click_pulse,
    output long_pulse,
    output repeat_pulse,
    output held
  );
endinterface

// File: rtl/button_press_ctrl.sv
// Turns a debounced button level into press/release/click/long/repeat events.
// Ports: clk_in, reset_in (async, active-high), bus (slave): button_in in,
//   press/release/click/long/repeat pulses and held level out, all registered.
module button_press_ctrl #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input logic           clk_in,
  input logic           reset_in,
  button_press_ctrl_if.slave bus
);

  localparam int MAX_CYC =
    (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] LONG_LAST =
    CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST =
    CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_REL,
    IDLE,
    SHORT,
    LONG
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state             <= WAIT_REL;
      cnt               <= '0;
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.click_pulse   <= 1'b0;
      bus.long_pulse    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
      bus.held          <= 1'b0;
    end else begin
      bus.press_pulse   <= 1'b0;
      bus.release_pulse <= 1'b0;
      bus.click_pulse   <= 1'b0;
      bus.long_pulse    <= 1'b0;
      bus.repeat_pulse  <= 1'b0;
      unique case (state)
        // A button held through reset must be seen low first.
        WAIT_REL: begin
          if (!bus.button_in) state <= IDLE;
        end
        IDLE: begin
          if (bus.button_in) begin
            state           <= SHORT;
            cnt             <= '0;
            bus.press_pulse <= 1'b1;
            bus.held        <= 1'b1;
          end
        end
        // Release takes priority over a threshold hit.
        SHORT: begin
          if (!bus.button_in) begin
            state             <= IDLE;
            bus.release_pulse <= 1'b1;
            bus.click_pulse   <= 1'b1;
            bus.held          <= 1'b0;
          end else if (cnt == LONG_LAST) begin
            state          <= LONG;
            cnt            <= '0;
            bus.long_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LONG: begin
          if (!bus.button_in) begin
            state             <= IDLE;
            bus.release_pulse <= 1'b1;
            bus.held          <= 1'b0;
          end else if (cnt == REP_LAST) begin
            cnt              <= '0;
            bus.repeat_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= WAIT_REL;
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_ctrl.sv
// Scoreboard bench for button_press_ctrl with a hold-duration reference model.
// Output vector order: {press, release, click, long, repeat, held}.
module tb_button_press_ctrl;

  localparam int LONG = 8;
  localparam int REP  = 4;

  logic clk_in;
  logic reset_in;

  button_press_ctrl_if bus ();

  button_press_ctrl #(
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .bus     (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int compared;
  int mismatched;

  logic [5:0] sbq[$];

  function automatic logic [5:0] outs();
    return {bus.press_pulse, bus.release_pulse,
            bus.click_pulse, bus.long_pulse,
            bus.repeat_pulse, bus.held};
  endfunction

  task automatic chk(string nm, logic [5:0] act, logic [5:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s t=%0t got=%b want=%b", nm, $time, act, exp);
    end
  endtask

  // Reference: armed once low seen after reset; k = edges held since press.
  bit armed;
  bit pressed;
  int k;

  always @(posedge clk_in or posedge reset_in) begin
    logic [5:0] e;
    if (reset_in) begin
      armed   = 1'b0;
      pressed = 1'b0;
      k       = 0;
      sbq.delete();
    end else begin
      e = '0;
      if (!armed) begin
        if (!bus.button_in) armed = 1'b1;
      end else if (!pressed) begin
        if (bus.button_in) begin
          pressed = 1'b1;
          k       = 0;
          e[5]    = 1'b1;
        end
      end else if (!bus.button_in) begin
        pressed = 1'b0;
        e[4]    = 1'b1;
        e[3]    = (k < LONG);
      end else begin
        k++;
        if (k == LONG) e[2] = 1'b1;
        else if (k > LONG && (k - LONG) % REP == 0) e[1] = 1'b1;
      end
      e[0] = pressed;
      sbq.push_back(e);
    end
  end

  always @(negedge clk_in) begin
    if (reset_in) begin
      chk("reset_outs", outs(), 6'b0);
    end else if (sbq.size() > 0) begin
      chk("cycle_outs", outs(), sbq.pop_front());
    end
  end

  task automatic drive(bit b, int n);
    bus.button_in = b;
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  task automatic do_reset(bit b);
    reset_in      = 1'b1;
    bus.button_in = b;
    repeat (2) @(posedge clk_in);
    #2;
    reset_in = 1'b0;
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    reset_in      = 1'b1;
    bus.button_in = 1'b0;
    #1;
    chk("async_reset_start", outs(), 6'b0);
    repeat (2) @(posedge clk_in);
    #2;
    reset_in = 1'b0;

    // short click
    drive(0, 2);
    drive(1, 3);
    drive(0, 3);
    // long hold with repeats
    drive(1, 21);
    drive(0, 3);
    // release exactly at long threshold edge
    drive(1, 8);
    drive(0, 3);
    // held through reset: must be released first
    do_reset(1);
    drive(1, 30);
    drive(0, 1);
    drive(1, 3);
    drive(0, 2);
    // async reset mid-cycle during LONG
    drive(1, 12);
    reset_in = 1'b1;
    #1;
    chk("async_reset_long", outs(), 6'b0);
    @(posedge clk_in);
    #2;
    reset_in = 1'b0;
    drive(1, 3);
    drive(0, 2);
    drive(1, 12);
    drive(0, 2);
    // back-to-back single-cycle presses
    drive(1, 1);
    drive(0, 1);
    drive(1, 1);
    drive(0, 3);

    // randomized holds, gaps and occasional resets
    for (int i = 0; i < 40; i++) begin
      drive(1, $urandom_range(1, 24));
      if ($urandom_range(0, 7) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end
      drive(0, $urandom_range(1, 3));
    end

    drive(0, 3);
    @(negedge clk_in);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
